decoder_3_8: RTL and testbench
==============================

// Module: decoder_3_8
// PURPOSE
//  - Binary-to-one-hot decoder with enable: a 3-bit select drives exactly one of 8 output lines high.
//  - Used as a chip-select / row-select generator; sits between address/control logic and per-slot enables.
//  - Output is registered by default (one clock latency) with a synchronous reset.
//  - A combinational build option is available for glue paths.
// PARAMETERS
//  SEL_W       3   select width; output width is 2**SEL_W (default 8)
//  OUT_REG     1   1 = OUT registered on clk (1-cycle latency); 0 = OUT purely combinational
//  ACTIVE_LOW  0   1 = invert OUT polarity (selected line low, others high)
// PORTS
//  clk   in   1          rising-edge clock
//  rst   in   1          synchronous reset, active-high
//  IN    in   SEL_W      binary select code
//  EN    in   1          decode enable; 0 forces all outputs deasserted
//  OUT   out  2**SEL_W   one-hot decoded output; bit k asserted when IN==k and EN==1
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-high (clk, rst).
//  - Decode function: dec[k] = EN & (IN == k), for k = 0 .. 2**SEL_W-1.
//  - Exactly one bit of dec is set when EN=1; no bit is set when EN=0.
//  - Polarity: OUT = ACTIVE_LOW ? ~dec : dec.
//  - "Deasserted" below means all-zero for ACTIVE_LOW=0 and all-ones for ACTIVE_LOW=1.
//  - OUT_REG=1:
//      - OUT updates on the rising clk edge from the IN/EN values sampled at that edge.
//      - Latency is exactly 1 cycle; a new code can be accepted every cycle.
//      - rst=1 at an edge loads deasserted OUT, and rst has priority over EN/IN.
//      - After rst deasserts, the first decoded value appears at the next edge.
//  - OUT_REG=0:
//      - OUT follows IN/EN combinationally with zero latency.
//      - clk and rst are ignored.
//  - Reset value of OUT after power-up is unspecified until the first rst edge (OUT_REG=1).
//  - Boundary codes: IN=0 -> bit 0; IN=2**SEL_W-1 -> MSB. IN has no out-of-range values.
//  - EN falling mid-stream:
//      - OUT_REG=1: OUT deasserts at the next edge.
//      - OUT_REG=0: OUT deasserts immediately.
//  - IN and EN changing together: the registered output reflects both values sampled at the same edge.
//    No glitch state is ever captured.
//  - Invariant, checked by assertion: popcount(dec) == EN.
// STRUCTURE
//  - Shared package: localparam function for OUT width (2**SEL_W), and the polarity and registration enums/constants.
//  - One natural sub-module, decoder_3_8_core:
//      - Combinational, parameterised by SEL_W, generate loop of equality compares ANDed with EN.
//  - Top level wraps the core with:
//      - the polarity XOR stage;
//      - an optional output register (generate on OUT_REG) with synchronous rst.
// TESTING
//  - Reset: rst=1 for 2 cycles with EN=1, IN=5
//      -> OUT=8'h00; the first edge after rst=0 gives OUT=8'h20.
//  - Disabled sweep: EN=0, IN=0..7 one per cycle -> OUT=8'h00 every cycle.
//  - Enabled sweep: EN=1, IN=0..7 one per cycle
//      -> OUT=01,02,04,08,10,20,40,80, each 1 cycle after its IN.
//  - Back-to-back and enable toggle: IN=3 with EN=1 then EN=0
//      -> OUT=8'h08, then 8'h00 on the next edge.
//  - Mid-stream reset: EN=1, IN=7, assert rst for 1 cycle -> OUT=8'h00 that edge;
//    the next edge with rst=0 gives OUT=8'h80.
//  - Parameter variants:
//      - ACTIVE_LOW=1, EN=1, IN=2 -> OUT=8'hFB.
//      - OUT_REG=0 -> OUT changes within the same cycle with no clk edge.
//      - SEL_W=4, IN=15 -> OUT=16'h8000.

Source files
------------

// File: rtl/decoder_3_8_pkg.sv
// Shared definitions for the 3-to-8 (parameterisable) one-hot decoder:
// output-width helper plus the polarity and registration mode encodings.
package decoder_3_8_pkg;

    // Output polarity of the decoded lines.
    typedef enum logic {
        POL_ACTIVE_HIGH = 1'b0,
        POL_ACTIVE_LOW  = 1'b1
    } pol_e;

    // Whether the decoded lines pass through a flop stage.
    typedef enum logic {
        OUT_COMB       = 1'b0,
        OUT_REGISTERED = 1'b1
    } out_mode_e;

    localparam int DEF_SEL_W = 3;

    // Number of one-hot lines produced by a SEL_W-bit select code.
    function automatic int out_width(input int sel_w);
        return 1 << sel_w;
    endfunction

endpackage

// File: rtl/decoder_3_8_core.sv
// Combinational one-hot decode: line k is high when the select equals k
// and the enable is set. No polarity handling or registration here.
module decoder_3_8_core
    import decoder_3_8_pkg::*;
#(
    parameter  int SEL_W = DEF_SEL_W,
    localparam int OUT_W = out_width(SEL_W)
) (
    input  logic [SEL_W-1:0] sel_i,
    input  logic             en_i,
    output logic [OUT_W-1:0] dec_o
);

    // One equality compare per output line, gated by the enable.
    for (genvar k = 0; k < OUT_W; k++) begin : g_line
        assign dec_o[k] = en_i & (sel_i == SEL_W'(k));
    end

endmodule

// File: rtl/decoder_3_8.sv
// Binary-to-one-hot decoder with enable, optional active-low outputs and
// an optional output register with synchronous active-high reset.
module decoder_3_8
    import decoder_3_8_pkg::*;
#(
    parameter  int SEL_W      = DEF_SEL_W,
    parameter  int OUT_REG    = 1,
    parameter  int ACTIVE_LOW = 0,
    localparam int OUT_W      = out_width(SEL_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] IN,
    input  logic             EN,
    output logic [OUT_W-1:0] OUT
);

    localparam pol_e      POL  = (ACTIVE_LOW != 0) ? POL_ACTIVE_LOW : POL_ACTIVE_HIGH;
    localparam out_mode_e MODE = (OUT_REG != 0) ? OUT_REGISTERED : OUT_COMB;

    // XOR mask for polarity; it is also the "all deasserted" pattern since
    // the decoded vector is all-zero when nothing is selected.
    localparam logic [OUT_W-1:0] POL_MASK = (POL == POL_ACTIVE_LOW) ? {OUT_W{1'b1}} : '0;

    logic [OUT_W-1:0] dec;
    logic [OUT_W-1:0] out_d;

    decoder_3_8_core #(
        .SEL_W (SEL_W)
    ) u_core (
        .sel_i (IN),
        .en_i  (EN),
        .dec_o (dec)
    );

    assign out_d = dec ^ POL_MASK;

    if (MODE == OUT_REGISTERED) begin : g_reg
        logic [OUT_W-1:0] out_q;

        // Capture IN/EN together each edge; reset wins over any decode.
        always_ff @(posedge clk) begin
            if (rst) out_q <= POL_MASK;
            else     out_q <= out_d;
        end

        assign OUT = out_q;
    end else begin : g_comb
        // Glue-path build: clock and reset have no effect.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign OUT = out_d;
    end

    // One line set exactly when enabled, none otherwise.
    a_onehot : assert property (@(posedge clk) disable iff (rst)
        $countones(dec) == int'(EN));

endmodule

// File: tb/tb_decoder_3_8.sv
module tb_decoder_3_8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [2:0]  in3 = 3'd0;
    logic [3:0]  in4 = 4'd0;
    logic [7:0]  out_r, out_al, out_c;
    logic [15:0] out_w;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decoder_3_8 #(.SEL_W(3), .OUT_REG(1), .ACTIVE_LOW(0)) dut_r (
        .clk(clk), .rst(rst), .IN(in3), .EN(en), .OUT(out_r));
    decoder_3_8 #(.SEL_W(3), .OUT_REG(1), .ACTIVE_LOW(1)) dut_al (
        .clk(clk), .rst(rst), .IN(in3), .EN(en), .OUT(out_al));
    decoder_3_8 #(.SEL_W(3), .OUT_REG(0), .ACTIVE_LOW(0)) dut_c (
        .clk(clk), .rst(rst), .IN(in3), .EN(en), .OUT(out_c));
    decoder_3_8 #(.SEL_W(4), .OUT_REG(1), .ACTIVE_LOW(0)) dut_w (
        .clk(clk), .rst(rst), .IN(in4), .EN(en), .OUT(out_w));

    typedef struct {
        logic       r;
        logic       e;
        logic [2:0] i;
        logic [7:0] x;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: one-hot of the code when enabled, nothing otherwise.
    function automatic logic [15:0] model(input int width, input logic e, input int code);
        logic [15:0] v;
        v = '0;
        if (e) v = 16'(1 << code);
        if (width == 8) v[15:8] = '0;
        return v;
    endfunction

    initial begin
        logic [7:0]  exp8;
        logic [15:0] expw;

        // Reset 2 cycles with EN=1, IN=5, then release.
        tbl.push_back('{1'b1, 1'b1, 3'd5, 8'h00});
        tbl.push_back('{1'b1, 1'b1, 3'd5, 8'h00});
        tbl.push_back('{1'b0, 1'b1, 3'd5, 8'h20});
        // Disabled sweep.
        for (int k = 0; k < 8; k++) tbl.push_back('{1'b0, 1'b0, 3'(k), 8'h00});
        // Enabled sweep.
        tbl.push_back('{1'b0, 1'b1, 3'd0, 8'h01});
        tbl.push_back('{1'b0, 1'b1, 3'd1, 8'h02});
        tbl.push_back('{1'b0, 1'b1, 3'd2, 8'h04});
        tbl.push_back('{1'b0, 1'b1, 3'd3, 8'h08});
        tbl.push_back('{1'b0, 1'b1, 3'd4, 8'h10});
        tbl.push_back('{1'b0, 1'b1, 3'd5, 8'h20});
        tbl.push_back('{1'b0, 1'b1, 3'd6, 8'h40});
        tbl.push_back('{1'b0, 1'b1, 3'd7, 8'h80});
        // Enable toggle.
        tbl.push_back('{1'b0, 1'b1, 3'd3, 8'h08});
        tbl.push_back('{1'b0, 1'b0, 3'd3, 8'h00});
        // Mid-stream reset.
        tbl.push_back('{1'b0, 1'b1, 3'd7, 8'h80});
        tbl.push_back('{1'b1, 1'b1, 3'd7, 8'h00});
        tbl.push_back('{1'b0, 1'b1, 3'd7, 8'h80});

        for (int n = 0; n < tbl.size(); n++) begin
            rst = tbl[n].r;
            en  = tbl[n].e;
            in3 = tbl[n].i;
            tick();
            chk($sformatf("tbl%0d_reg", n), {8'h00, out_r}, {8'h00, tbl[n].x});
            chk($sformatf("tbl%0d_al", n), {8'h00, out_al}, {8'h00, ~tbl[n].x});
        end

        // Active-low explicit: IN=2 -> FB.
        rst = 1'b0; en = 1'b1; in3 = 3'd2;
        tick();
        chk("al_in2", {8'h00, out_al}, 16'h00FB);

        // Combinational build: change within the cycle, no edge in between.
        in3 = 3'd6;
        #1;
        chk("comb_in6", {8'h00, out_c}, 16'h0040);
        chk("reg_holds", {8'h00, out_r}, 16'h0004);
        en = 1'b0;
        #1;
        chk("comb_en0", {8'h00, out_c}, 16'h0000);

        // Wide select, top code.
        en = 1'b1; in4 = 4'd15;
        tick();
        chk("wide_in15", out_w, 16'h8000);
        in4 = 4'd0;
        tick();
        chk("wide_in0", out_w, 16'h0001);

        // Randomised traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            rst = ($urandom_range(0, 15) == 0);
            en  = 1'($urandom_range(0, 3) != 0);
            in3 = 3'($urandom);
            in4 = 4'($urandom);
            #1;
            chk("rnd_comb", {8'h00, out_c}, model(8, en, int'(in3)));
            exp8 = rst ? 8'h00 : model(8, en, int'(in3)) >> 0;
            expw = rst ? 16'h0000 : model(16, en, int'(in4));
            tick();
            chk("rnd_reg", {8'h00, out_r}, {8'h00, exp8});
            chk("rnd_al", {8'h00, out_al}, {8'h00, ~exp8});
            chk("rnd_wide", out_w, expw);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
